// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side partner of the VGA timing generator. Watches hsync/vsync in
// the pixel-clock domain, recovers the position of the pixel currently on
// the inputs, checks sync edges against the expected timing and, once
// locked, regenerates pixel/line counters for downstream consumers.
//
// Ports:
//   pclk        in   pixel clock
//   reset       in   asynchronous, active-high reset
//   hsync       in   incoming horizontal sync
//   vsync       in   incoming vertical sync
//   clr_err     in   clears the sticky error bits
//   h_cnt[9:0]  out  recovered column while locked and h_pos < HD, else 0
//   v_cnt[9:0]  out  recovered line while locked and v_pos < VD, else 0
//   valid       out  locked and inside the visible area
//   locked      out  decoder is in the LOCKED state
//   frame_start out  one-cycle pulse at pixel (0,0) while locked
//   err[3:0]    out  sticky: [0] hsync period, [1] hsync width,
//                    [2] vsync position, [3] hsync timeout
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int   HD          = 640,
    parameter int   HF          = 16,
    parameter int   HS          = 96,
    parameter int   HB          = 48,
    parameter int   VD          = 480,
    parameter int   VF          = 10,
    parameter int   VS          = 2,
    parameter int   VB          = 33,
    parameter int   HSYNC_PIX   = HD + HF,
    parameter int   VSYNC_LINE  = VD + VF,
    parameter int   VSYNC_PIX   = 1,
    parameter logic SYNC_ACT    = 1'b0,
    parameter int   LOCK_FRAMES = 2,
    parameter int   TIMEOUT     = 2 * (HD + HF + HS + HB)
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       clr_err,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       locked,
    output logic       frame_start,
    output logic [3:0] err
);

    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    typedef enum logic [1:0] {SEARCH, HLOCK, ALIGN, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [9:0]  h_pos_q, h_pos_d;
    logic [9:0]  v_pos_q, v_pos_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [10:0] to_cnt_q, to_cnt_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [3:0]  err_q, err_d;

    logic hs_rise, hs_fall, vs_rise;
    logic timeout, err_per, err_wid, err_vs, any_err;

    always_comb begin
        hs_rise = (hsync == SYNC_ACT) && (hs_prev_q != SYNC_ACT);
        hs_fall = (hsync != SYNC_ACT) && (hs_prev_q == SYNC_ACT);
        vs_rise = (vsync == SYNC_ACT) && (vs_prev_q != SYNC_ACT);

        // Checks compare against the position of the pixel on the inputs now.
        timeout = (to_cnt_q == 11'(TIMEOUT));
        err_per = (state_q != SEARCH) && hs_rise && (h_pos_q != 10'(HSYNC_PIX));
        err_wid = (state_q != SEARCH) && hs_fall && (h_pos_q != 10'(HSYNC_PIX + HS));
        err_vs  = ((state_q == ALIGN) || (state_q == LOCKED)) && vs_rise &&
                  ((v_pos_q != 10'(VSYNC_LINE)) || (h_pos_q != 10'(VSYNC_PIX)));
        any_err = err_per || err_wid || err_vs || timeout;

        hs_prev_d  = hsync;
        vs_prev_d  = vsync;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;

        // Free-running raster position.
        if (h_pos_q == 10'(HT - 1)) begin
            h_pos_d = '0;
            v_pos_d = (v_pos_q == 10'(VT - 1)) ? '0 : v_pos_q + 10'd1;
        end else begin
            h_pos_d = h_pos_q + 10'd1;
            v_pos_d = v_pos_q;
        end
        // Line count is meaningless until vertical alignment.
        if ((state_q == SEARCH) || (state_q == HLOCK)) begin
            v_pos_d = '0;
        end

        // Saturates so an expiry is flagged only once per hsync loss.
        if (hs_rise) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == 11'h7ff) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + 11'd1;
        end

        // A new error in the same cycle as clr_err survives.
        err_d = clr_err ? 4'b0000 : err_q;
        err_d = err_d | {timeout, err_vs, err_wid, err_per};

        if (any_err) begin
            // The offending edge is not used for realignment.
            state_d    = SEARCH;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (hs_rise) begin
                        h_pos_d = 10'(HSYNC_PIX + 1);
                        state_d = HLOCK;
                    end
                end
                HLOCK: begin
                    if (vs_rise) begin
                        v_pos_d    = 10'(VSYNC_LINE);
                        good_cnt_d = '0;
                        state_d    = ALIGN;
                    end
                end
                ALIGN: begin
                    if (vs_rise) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if ((good_cnt_q + 4'd1) >= 4'(LOCK_FRAMES)) begin
                            state_d = LOCKED;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            h_pos_q    <= '0;
            v_pos_q    <= '0;
            good_cnt_q <= '0;
            to_cnt_q   <= '0;
            hs_prev_q  <= ~SYNC_ACT;
            vs_prev_q  <= ~SYNC_ACT;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            h_pos_q    <= h_pos_d;
            v_pos_q    <= v_pos_d;
            good_cnt_q <= good_cnt_d;
            to_cnt_q   <= to_cnt_d;
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        locked      = (state_q == LOCKED);
        h_cnt       = (locked && (h_pos_q < 10'(HD))) ? h_pos_q : '0;
        v_cnt       = (locked && (v_pos_q < 10'(VD))) ? v_pos_q : '0;
        valid       = locked && (h_pos_q < 10'(HD)) && (v_pos_q < 10'(VD));
        frame_start = locked && (h_pos_q == '0) && (v_pos_q == '0);
        err         = err_q;
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder using a reduced raster (25 x 15) so
// several lock/relock sequences fit in a short run. A behavioural sync
// generator drives hsync/vsync; expected counters come from the generator's
// own position.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HD = 16, HF = 2, HS = 4, HB = 3;
    localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT  = HD + HF + HS + HB;   // 25
    localparam int VT  = VD + VF + VS + VB;   // 15
    localparam int HSP = HD + HF;             // 18
    localparam int VSL = VD + VF;             // 10
    localparam int TO  = 2 * HT;              // 50

    logic       pclk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       clr_err;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       locked;
    logic       frame_start;
    logic [3:0] err;

    int n_assert = 0;
    int n_fail   = 0;

    int   gh, gv, gf;
    bit   chk_out, stretch, short_hs, hold_hs, exp_lock;
    logic [3:0] exp_err;

    always #5 pclk = ~pclk;

    vga_sync_decoder #(
        .HD(HD), .HF(HF), .HS(HS), .HB(HB),
        .VD(VD), .VF(VF), .VS(VS), .VB(VB),
        .TIMEOUT(TO)
    ) u_dut (
        .pclk        (pclk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .clr_err     (clr_err),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .locked      (locked),
        .frame_start (frame_start),
        .err         (err)
    );

    function automatic logic gen_hs();
        int  w;
        w = short_hs ? HS - 1 : HS;
        return (!hold_hs && gh >= HSP && gh < HSP + w) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic gen_vs();
        int p;
        p = gv * HT + gh;
        return (p >= VSL * HT + 1 && p <= (VSL + VS) * HT) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [26:0] obs_vec();
        return {locked, valid, frame_start, err, h_cnt, v_cnt};
    endfunction

    function automatic logic [26:0] exp_vec();
        logic [9:0] eh, ev;
        logic       ev_ok, fs;
        eh    = (exp_lock && gh < HD) ? 10'(gh) : 10'd0;
        ev    = (exp_lock && gv < VD) ? 10'(gv) : 10'd0;
        ev_ok = exp_lock && gh < HD && gv < VD;
        fs    = exp_lock && gh == 0 && gv == 0;
        return {exp_lock, ev_ok, fs, exp_err, eh, ev};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the current pixel, clock it in, then check the outputs against
    // the pixel that is next on the inputs.
    task automatic tick();
        hsync = gen_hs();
        vsync = gen_vs();
        @(posedge pclk);
        #1;
        if (stretch && gh == HT - 1) begin
            stretch = 1'b0;
        end else begin
            gh++;
            if (gh == HT) begin
                gh = 0;
                gv++;
                if (gv == VT) begin
                    gv = 0;
                    gf++;
                end
            end
        end
        if (chk_out) chk("track", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int f, input int l, input int p);
        int k;
        k = 0;
        while (!(gf == f && gv == l && gh == p) && k < 4000) begin
            tick();
            k++;
        end
        if (k >= 4000) begin
            n_assert++;
            n_fail++;
            $error("FAIL bound: position %0d/%0d/%0d not reached, at %0d/%0d/%0d",
                   f, l, p, gf, gv, gh);
        end
    endtask

    // Lock is expected right after the third vsync edge following realignment.
    task automatic relock(input int f);
        exp_lock = 1'b0;
        run_until(f + 2, VSL, 1);
        chk("pre_lock", 32'(locked), 32'd0);
        exp_lock = 1'b1;
        tick();
        chk("lock", 32'(locked), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        clr_err  = 1'b0;
        hsync    = 1'b1;
        vsync    = 1'b1;
        gh = 0; gv = 0; gf = 0;
        chk_out  = 1'b0;
        stretch  = 1'b0;
        short_hs = 1'b0;
        hold_hs  = 1'b0;
        exp_lock = 1'b0;
        exp_err  = 4'b0000;

        // Test 1: reset state, acquisition, tracking, frame_start.
        #12;
        chk("reset_state", 32'(obs_vec()), 32'd0);
        reset   = 1'b0;
        chk_out = 1'b1;
        relock(0);
        run_until(3, 0, 0);
        chk("frame_start_hi", 32'(frame_start), 32'd1);
        tick();
        chk("frame_start_lo", 32'(frame_start), 32'd0);
        run_until(3, 2, HT - 1);

        // Test 2: one line stretched by a pixel.
        stretch = 1'b1;
        chk_out = 1'b0;
        run_until(3, 3, HSP);
        chk("t2_pre", 32'({locked, err}), 32'h10);
        tick();
        chk("t2_err", 32'(err), 32'h1);
        chk("t2_unlock", 32'(locked), 32'd0);
        exp_lock = 1'b0;
        exp_err  = 4'b0001;
        chk_out  = 1'b1;

        // Test 5a: clr_err on its own.
        exp_err = 4'b0000;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_clr", 32'(err), 32'd0);
        relock(3);

        // Test 5b: clr_err coincident with a new period error.
        run_until(6, 2, HT - 1);
        stretch = 1'b1;
        chk_out = 1'b0;
        run_until(6, 3, HSP);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_setwins", 32'(err), 32'h1);
        chk("t5_unlock", 32'(locked), 32'd0);
        exp_lock = 1'b0;
        exp_err  = 4'b0000;
        chk_out  = 1'b1;
        clr_err  = 1'b1;
        tick();
        clr_err  = 1'b0;
        relock(6);

        // Test 3: one hsync pulse a cycle short.
        run_until(9, 3, 0);
        short_hs = 1'b1;
        run_until(9, 3, HSP + HS - 1);
        chk("t3_pre", 32'(locked), 32'd1);
        exp_lock = 1'b0;
        exp_err  = 4'b0010;
        tick();
        short_hs = 1'b0;
        chk("t3_err", 32'(err), 32'h2);
        chk("t3_unlock", 32'(locked), 32'd0);
        run_until(9, 5, 0);
        chk("t3_no_period_err", 32'(err[0]), 32'd0);
        exp_err = 4'b0000;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        relock(9);

        // Test 4: hsync lost; timeout fires exactly TO cycles after the last rise.
        run_until(12, 5, HSP + 1);
        run(HS);
        hold_hs = 1'b1;
        run(TO - HS);
        chk("t4_pre", 32'({locked, err}), 32'h10);
        exp_lock = 1'b0;
        exp_err  = 4'b1000;
        tick();
        chk("t4_err", 32'(err), 32'h8);
        chk("t4_unlock", 32'(locked), 32'd0);
        chk("t4_counts", 32'({h_cnt, v_cnt}), 32'd0);
        exp_err = 4'b0000;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        run(100);
        chk("t4_once", 32'(err), 32'd0);
        run_until(13, 0, 0);
        hold_hs = 1'b0;
        relock(13);

        // Test 6: asynchronous reset mid-frame, then reacquire from scratch.
        run_until(16, 4, 7);
        chk("t6_pre", 32'(h_cnt), 32'd7);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async", 32'(obs_vec()), 32'd0);
        #20;
        reset    = 1'b0;
        gh = 0; gv = 0; gf = 0;
        exp_lock = 1'b0;
        exp_err  = 4'b0000;
        relock(0);
        run_until(3, 1, 0);
        chk("t6_err_clean", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
